// File: rtl/sdram_port_arb.sv
// Two-port round-robin arbiter in front of an SDRAM core. Write bursts lock the
// grant until the last beat; a tag FIFO routes each response back to its port.
module sdram_port_arb #(
   parameter int unsigned TAG_DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  p0_wr_i,
   input  logic        p0_rd_i,
   input  logic [7:0]  p0_len_i,
   input  logic [31:0] p0_addr_i,
   input  logic [31:0] p0_write_data_i,
   output logic        p0_accept_o,
   output logic        p0_ack_o,
   output logic        p0_error_o,
   output logic [31:0] p0_read_data_o,
   input  logic [3:0]  p1_wr_i,
   input  logic        p1_rd_i,
   input  logic [7:0]  p1_len_i,
   input  logic [31:0] p1_addr_i,
   input  logic [31:0] p1_write_data_i,
   output logic        p1_accept_o,
   output logic        p1_ack_o,
   output logic        p1_error_o,
   output logic [31:0] p1_read_data_o,
   output logic [3:0]  ram_wr_o,
   output logic        ram_rd_o,
   output logic [7:0]  ram_len_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_write_data_o,
   input  logic        ram_accept_i,
   input  logic        ram_ack_i,
   input  logic        ram_error_i,
   input  logic [31:0] ram_read_data_i,
   output logic        arb_err_o
);

   localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {ST_IDLE, ST_LOCK} state_e;

   state_e                 state_q, state_d;
   logic                   gnt_q, gnt_d;
   logic                   lw_q, lw_d;
   logic [7:0]             beat_q, beat_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [TAG_DEPTH-1:0]   tag_q, tag_d;
   logic                   arb_err_q, arb_err_d;

   logic        req0, req1, win, win_req, win_rd;
   logic [3:0]  win_wr;
   logic [7:0]  win_len;
   logic        fifo_full, fifo_empty, fwd, accept, pop, head;

   // Winner selection: round robin in IDLE, held grant in LOCK
   always_comb begin
      req0 = p0_rd_i | (|p0_wr_i);
      req1 = p1_rd_i | (|p1_wr_i);
      if (state_q == ST_LOCK)  win = gnt_q;
      else if (req0 && req1)   win = ~lw_q;
      else                     win = req1;
      win_req    = win ? req1     : req0;
      win_wr     = win ? p1_wr_i  : p0_wr_i;
      win_rd     = win ? p1_rd_i  : p0_rd_i;
      win_len    = win ? p1_len_i : p0_len_i;
      fifo_full  = (cnt_q == CNT_W'(TAG_DEPTH));
      fifo_empty = (cnt_q == '0);
      fwd        = win_req & ~fifo_full & ~rst_i;
      accept     = fwd & ram_accept_i;
      pop        = ram_ack_i & ~fifo_empty & ~rst_i;
      head       = tag_q[rd_ptr_q];
   end

   assign ram_wr_o         = fwd ? win_wr : 4'h0;
   assign ram_rd_o         = fwd & win_rd & (win_wr == 4'h0);
   assign ram_len_o        = win_len;
   assign ram_addr_o       = win ? p1_addr_i       : p0_addr_i;
   assign ram_write_data_o = win ? p1_write_data_i : p0_write_data_i;

   assign p0_accept_o    = accept & ~win;
   assign p1_accept_o    = accept & win;
   assign p0_ack_o       = pop & ~head;
   assign p1_ack_o       = pop & head;
   assign p0_error_o     = pop & ~head & ram_error_i;
   assign p1_error_o     = pop & head & ram_error_i;
   assign p0_read_data_o = (pop & ~head) ? ram_read_data_i : 32'h0;
   assign p1_read_data_o = (pop & head)  ? ram_read_data_i : 32'h0;
   assign arb_err_o      = arb_err_q;

   // Next-state: burst lock, tag FIFO bookkeeping, sticky orphan-ack flag
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      lw_d      = lw_q;
      beat_d    = beat_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      tag_d     = tag_q;
      arb_err_d = arb_err_q | (ram_ack_i & fifo_empty);

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if ((win_wr != 4'h0) && (win_len != 8'd0)) begin
                  state_d = ST_LOCK;
                  gnt_d   = win;
                  beat_d  = win_len;
               end else begin
                  lw_d = win;
               end
            end
         end
         ST_LOCK: begin
            if (accept) begin
               if (beat_q == 8'd1) begin
                  state_d = ST_IDLE;
                  lw_d    = gnt_q;
                  beat_d  = 8'd0;
               end else begin
                  beat_d = beat_q - 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         tag_d[wr_ptr_q] = win;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({accept, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 1'b0;
         lw_q      <= 1'b1;
         beat_q    <= 8'd0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         arb_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         lw_q      <= lw_d;
         beat_q    <= beat_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         arb_err_q <= arb_err_d;
      end
   end

   // Tag storage needs no reset; only slots between the pointers are read
   always_ff @(posedge clk_i) begin
      tag_q <= tag_d;
   end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: round robin, burst lock, tag FIFO full /
// concurrent push-pop, orphan acks and reset mid-burst.
`timescale 1ns/1ps
module tb_sdram_port_arb;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  p0_wr_i, p1_wr_i;
   logic        p0_rd_i, p1_rd_i;
   logic [7:0]  p0_len_i, p1_len_i;
   logic [31:0] p0_addr_i, p1_addr_i, p0_write_data_i, p1_write_data_i;
   logic        p0_accept_o, p0_ack_o, p0_error_o;
   logic        p1_accept_o, p1_ack_o, p1_error_o;
   logic [31:0] p0_read_data_o, p1_read_data_o;
   logic [3:0]  ram_wr_o;
   logic        ram_rd_o;
   logic [7:0]  ram_len_o;
   logic [31:0] ram_addr_o, ram_write_data_o;
   logic        ram_accept_i, ram_ack_i, ram_error_i;
   logic [31:0] ram_read_data_i;
   logic        arb_err_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   sdram_port_arb #(.TAG_DEPTH(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p0_wr_i(p0_wr_i), .p0_rd_i(p0_rd_i), .p0_len_i(p0_len_i), .p0_addr_i(p0_addr_i),
      .p0_write_data_i(p0_write_data_i), .p0_accept_o(p0_accept_o), .p0_ack_o(p0_ack_o),
      .p0_error_o(p0_error_o), .p0_read_data_o(p0_read_data_o),
      .p1_wr_i(p1_wr_i), .p1_rd_i(p1_rd_i), .p1_len_i(p1_len_i), .p1_addr_i(p1_addr_i),
      .p1_write_data_i(p1_write_data_i), .p1_accept_o(p1_accept_o), .p1_ack_o(p1_ack_o),
      .p1_error_o(p1_error_o), .p1_read_data_o(p1_read_data_o),
      .ram_wr_o(ram_wr_o), .ram_rd_o(ram_rd_o), .ram_len_o(ram_len_o), .ram_addr_o(ram_addr_o),
      .ram_write_data_o(ram_write_data_o), .ram_accept_i(ram_accept_i), .ram_ack_i(ram_ack_i),
      .ram_error_i(ram_error_i), .ram_read_data_i(ram_read_data_i), .arb_err_o(arb_err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      p0_wr_i = 4'h0; p0_rd_i = 1'b0; p0_len_i = 8'd0; p0_addr_i = 32'h0; p0_write_data_i = 32'h0;
      p1_wr_i = 4'h0; p1_rd_i = 1'b0; p1_len_i = 8'd0; p1_addr_i = 32'h0; p1_write_data_i = 32'h0;
      ram_accept_i = 1'b0; ram_ack_i = 1'b0; ram_error_i = 1'b0; ram_read_data_i = 32'h0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      clear_inputs();
      p0_rd_i = 1'b1; p1_wr_i = 4'hF; ram_accept_i = 1'b1; ram_ack_i = 1'b1; ram_error_i = 1'b1;
      repeat (2) @(negedge clk_i);
      #1;
      total_cnt++; if (p0_accept_o !== 1'b0) $display("FAIL rst_p0_accept got=%b exp=0", p0_accept_o); else pass_cnt++;
      total_cnt++; if (p1_accept_o !== 1'b0) $display("FAIL rst_p1_accept got=%b exp=0", p1_accept_o); else pass_cnt++;
      total_cnt++; if (ram_rd_o !== 1'b0) $display("FAIL rst_ram_rd got=%b exp=0", ram_rd_o); else pass_cnt++;
      total_cnt++; if (ram_wr_o !== 4'h0) $display("FAIL rst_ram_wr got=%h exp=0", ram_wr_o); else pass_cnt++;
      total_cnt++; if ({p0_ack_o, p1_ack_o, p0_error_o, p1_error_o} !== 4'b0) $display("FAIL rst_ack_err got=%b exp=0000", {p0_ack_o, p1_ack_o, p0_error_o, p1_error_o}); else pass_cnt++;
      total_cnt++; if (arb_err_o !== 1'b0) $display("FAIL rst_arb_err got=%b exp=0", arb_err_o); else pass_cnt++;
      @(negedge clk_i);
      rst_i = 1'b0;
      clear_inputs();
      #1;
      total_cnt++; if (ram_rd_o !== 1'b0) $display("FAIL idle_ram_rd got=%b exp=0", ram_rd_o); else pass_cnt++;
      @(negedge clk_i);
   endtask

   task automatic test_round_robin();
      logic e;
      p0_rd_i = 1'b1; p1_rd_i = 1'b1; p0_addr_i = 32'h100; p1_addr_i = 32'h200; ram_accept_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = i[0];
         #1;
         total_cnt++; if (p0_accept_o !== ~e) $display("FAIL rr_p0_accept[%0d] got=%b exp=%b", i, p0_accept_o, ~e); else pass_cnt++;
         total_cnt++; if (p1_accept_o !== e) $display("FAIL rr_p1_accept[%0d] got=%b exp=%b", i, p1_accept_o, e); else pass_cnt++;
         total_cnt++; if (ram_addr_o !== (e ? 32'h200 : 32'h100)) $display("FAIL rr_ram_addr[%0d] got=%h exp=%h", i, ram_addr_o, e ? 32'h200 : 32'h100); else pass_cnt++;
         @(negedge clk_i);
      end
      clear_inputs();
      ram_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = i[0];
         ram_read_data_i = 32'hA0 + 32'(i);
         #1;
         total_cnt++; if ({p1_ack_o, p0_ack_o} !== {e, ~e}) $display("FAIL rr_ack[%0d] got=%b%b exp=%b%b", i, p1_ack_o, p0_ack_o, e, ~e); else pass_cnt++;
         total_cnt++; if ((e ? p1_read_data_o : p0_read_data_o) !== 32'hA0 + 32'(i)) $display("FAIL rr_rdata[%0d] got=%h exp=%h", i, e ? p1_read_data_o : p0_read_data_o, 32'hA0 + 32'(i)); else pass_cnt++;
         total_cnt++; if ((e ? p0_read_data_o : p1_read_data_o) !== 32'h0) $display("FAIL rr_other_rdata[%0d] got=%h exp=0", i, e ? p0_read_data_o : p1_read_data_o); else pass_cnt++;
         @(negedge clk_i);
      end
      clear_inputs();
   endtask

   task automatic test_burst_lock();
      logic e;
      p0_wr_i = 4'hF; p0_len_i = 8'd3; p0_addr_i = 32'h300; p0_write_data_i = 32'h1111_2222;
      p1_rd_i = 1'b1; p1_addr_i = 32'h400; ram_accept_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         e = (i == 4);
         #1;
         total_cnt++; if (p0_accept_o !== ~e) $display("FAIL burst_p0_accept[%0d] got=%b exp=%b", i, p0_accept_o, ~e); else pass_cnt++;
         total_cnt++; if (p1_accept_o !== e) $display("FAIL burst_p1_accept[%0d] got=%b exp=%b", i, p1_accept_o, e); else pass_cnt++;
         total_cnt++; if (ram_wr_o !== (e ? 4'h0 : 4'hF)) $display("FAIL burst_ram_wr[%0d] got=%h exp=%h", i, ram_wr_o, e ? 4'h0 : 4'hF); else pass_cnt++;
         total_cnt++; if (ram_rd_o !== e) $display("FAIL burst_ram_rd[%0d] got=%b exp=%b", i, ram_rd_o, e); else pass_cnt++;
         if (!e) begin
            total_cnt++; if (ram_write_data_o !== 32'h1111_2222) $display("FAIL burst_wdata[%0d] got=%h exp=11112222", i, ram_write_data_o); else pass_cnt++;
         end
         @(negedge clk_i);
      end
      clear_inputs();
      ram_ack_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         e = (i == 4);
         #1;
         total_cnt++; if ({p1_ack_o, p0_ack_o} !== {e, ~e}) $display("FAIL burst_ack[%0d] got=%b%b exp=%b%b", i, p1_ack_o, p0_ack_o, e, ~e); else pass_cnt++;
         @(negedge clk_i);
      end
      clear_inputs();
   endtask

   task automatic test_fifo_full();
      p0_rd_i = 1'b1; ram_accept_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         total_cnt++; if (p0_accept_o !== 1'b1) $display("FAIL fill_accept[%0d] got=%b exp=1", i, p0_accept_o); else pass_cnt++;
         @(negedge clk_i);
      end
      #1;
      total_cnt++; if (p0_accept_o !== 1'b0) $display("FAIL full_accept got=%b exp=0", p0_accept_o); else pass_cnt++;
      total_cnt++; if (ram_rd_o !== 1'b0) $display("FAIL full_ram_rd got=%b exp=0", ram_rd_o); else pass_cnt++;
      @(negedge clk_i);
      ram_ack_i = 1'b1;
      #1;
      total_cnt++; if (p0_accept_o !== 1'b0) $display("FAIL full_pop_accept got=%b exp=0", p0_accept_o); else pass_cnt++;
      total_cnt++; if (p0_ack_o !== 1'b1) $display("FAIL full_pop_ack got=%b exp=1", p0_ack_o); else pass_cnt++;
      @(negedge clk_i);
      ram_ack_i = 1'b0;
      #1;
      total_cnt++; if (p0_accept_o !== 1'b1) $display("FAIL resume_accept got=%b exp=1", p0_accept_o); else pass_cnt++;
      @(negedge clk_i);
      clear_inputs();
      ram_ack_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         total_cnt++; if (p0_ack_o !== 1'b1) $display("FAIL full_drain_ack[%0d] got=%b exp=1", i, p0_ack_o); else pass_cnt++;
         @(negedge clk_i);
      end
      clear_inputs();
   endtask

   task automatic test_push_pop_same_cycle();
      logic e;
      p1_rd_i = 1'b1; ram_accept_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total_cnt++; if (p1_accept_o !== 1'b1) $display("FAIL pp_fill_accept[%0d] got=%b exp=1", i, p1_accept_o); else pass_cnt++;
         @(negedge clk_i);
      end
      p1_rd_i = 1'b0; p0_rd_i = 1'b1;
      ram_ack_i = 1'b1; ram_error_i = 1'b1; ram_read_data_i = 32'hDEAD_BEEF;
      #1;
      total_cnt++; if (p0_accept_o !== 1'b1) $display("FAIL pp_accept got=%b exp=1", p0_accept_o); else pass_cnt++;
      total_cnt++; if ({p1_ack_o, p0_ack_o} !== 2'b10) $display("FAIL pp_ack got=%b%b exp=10", p1_ack_o, p0_ack_o); else pass_cnt++;
      total_cnt++; if ({p1_error_o, p0_error_o} !== 2'b10) $display("FAIL pp_error got=%b%b exp=10", p1_error_o, p0_error_o); else pass_cnt++;
      total_cnt++; if (p1_read_data_o !== 32'hDEAD_BEEF) $display("FAIL pp_p1_rdata got=%h exp=deadbeef", p1_read_data_o); else pass_cnt++;
      total_cnt++; if (p0_read_data_o !== 32'h0) $display("FAIL pp_p0_rdata got=%h exp=0", p0_read_data_o); else pass_cnt++;
      @(negedge clk_i);
      ram_ack_i = 1'b0; ram_error_i = 1'b0; ram_read_data_i = 32'h0;
      for (int i = 0; i < 5; i++) begin
         e = (i < 4);
         #1;
         total_cnt++; if (p0_accept_o !== e) $display("FAIL pp_occ_accept[%0d] got=%b exp=%b", i, p0_accept_o, e); else pass_cnt++;
         @(negedge clk_i);
      end
      clear_inputs();
      ram_ack_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         e = (i < 3);
         #1;
         total_cnt++; if ({p1_ack_o, p0_ack_o} !== {e, ~e}) $display("FAIL pp_drain_ack[%0d] got=%b%b exp=%b%b", i, p1_ack_o, p0_ack_o, e, ~e); else pass_cnt++;
         @(negedge clk_i);
      end
      clear_inputs();
   endtask

   task automatic test_empty_ack();
      #1;
      total_cnt++; if (arb_err_o !== 1'b0) $display("FAIL pre_arb_err got=%b exp=0", arb_err_o); else pass_cnt++;
      @(negedge clk_i);
      ram_ack_i = 1'b1; ram_error_i = 1'b1; ram_read_data_i = 32'h5555_AAAA;
      #1;
      total_cnt++; if ({p0_ack_o, p1_ack_o, p0_error_o, p1_error_o} !== 4'b0) $display("FAIL orphan_ack got=%b exp=0000", {p0_ack_o, p1_ack_o, p0_error_o, p1_error_o}); else pass_cnt++;
      total_cnt++; if ((p0_read_data_o | p1_read_data_o) !== 32'h0) $display("FAIL orphan_rdata got=%h exp=0", p0_read_data_o | p1_read_data_o); else pass_cnt++;
      @(negedge clk_i);
      clear_inputs();
      #1;
      total_cnt++; if (arb_err_o !== 1'b1) $display("FAIL orphan_arb_err got=%b exp=1", arb_err_o); else pass_cnt++;
      repeat (3) @(negedge clk_i);
      #1;
      total_cnt++; if (arb_err_o !== 1'b1) $display("FAIL sticky_arb_err got=%b exp=1", arb_err_o); else pass_cnt++;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      total_cnt++; if (arb_err_o !== 1'b0) $display("FAIL cleared_arb_err got=%b exp=0", arb_err_o); else pass_cnt++;
      @(negedge clk_i);
   endtask

   task automatic test_reset_mid_burst();
      p0_wr_i = 4'hF; p0_len_i = 8'd3; ram_accept_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         total_cnt++; if (p0_accept_o !== 1'b1) $display("FAIL mid_beat_accept[%0d] got=%b exp=1", i, p0_accept_o); else pass_cnt++;
         @(negedge clk_i);
      end
      rst_i = 1'b1;
      #1;
      total_cnt++; if ({p0_accept_o, ram_wr_o} !== 5'b0) $display("FAIL mid_rst_outputs got=%b exp=00000", {p0_accept_o, ram_wr_o}); else pass_cnt++;
      @(negedge clk_i);
      rst_i = 1'b0;
      clear_inputs();
      p1_rd_i = 1'b1; ram_accept_i = 1'b1;
      #1;
      total_cnt++; if (p1_accept_o !== 1'b1) $display("FAIL post_rst_p1_accept got=%b exp=1", p1_accept_o); else pass_cnt++;
      total_cnt++; if (ram_rd_o !== 1'b1) $display("FAIL post_rst_ram_rd got=%b exp=1", ram_rd_o); else pass_cnt++;
      @(negedge clk_i);
      clear_inputs();
      ram_ack_i = 1'b1;
      #1;
      total_cnt++; if ({p1_ack_o, p0_ack_o} !== 2'b10) $display("FAIL post_rst_ack got=%b%b exp=10", p1_ack_o, p0_ack_o); else pass_cnt++;
      total_cnt++; if (arb_err_o !== 1'b0) $display("FAIL post_rst_arb_err0 got=%b exp=0", arb_err_o); else pass_cnt++;
      @(negedge clk_i);
      #1;
      total_cnt++; if ({p1_ack_o, p0_ack_o} !== 2'b00) $display("FAIL dropped_tag_ack got=%b%b exp=00", p1_ack_o, p0_ack_o); else pass_cnt++;
      @(negedge clk_i);
      clear_inputs();
      #1;
      total_cnt++; if (arb_err_o !== 1'b1) $display("FAIL dropped_tag_arb_err got=%b exp=1", arb_err_o); else pass_cnt++;
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_burst_lock();
      test_fifo_full();
      test_push_pop_same_cycle();
      test_empty_ack();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
